// File: rtl/serialize_seq_pkg.sv
// Shared types and sizing helpers for the serialize load/shift sequencer.
// SERIALIZE_SEQ_PARITY_EN appends one even-parity bit to every frame.
package serialize_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

`ifdef SERIALIZE_SEQ_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Index range must also cover the optional parity slot at WIDTH.
    function automatic int idx_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int frame_bits(input int width);
        return width + PARITY_BITS;
    endfunction

endpackage

// File: rtl/serialize_seq_period_cnt.sv
// Modulo-MOD cycle counter with synchronous clear; reports whether the
// coming cycle will be the terminal one so the owner can register its strobes.
module serialize_seq_period_cnt
    import serialize_seq_pkg::*;
#(
    parameter int MOD = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic wrap_next
);

    localparam int CW = (MOD > 1) ? $clog2(MOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(MOD - 1);

    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (en) begin
            count_next = (count == LAST) ? '0 : count + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    assign wrap_next = (count_next == LAST);

endmodule

// File: rtl/serialize_seq_ctrl.sv
// Handshaked load/shift sequencer: captures a word, strobes load, then paces
// MSB-first shift strobes. Optional parity bit via SERIALIZE_SEQ_PARITY_EN.
module serialize_seq_ctrl
    import serialize_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 1,
    parameter int GAP   = 1
) (
    input  logic                          input_clock_clk,
    input  logic                          input_push_button_rst_n,
    input  logic                          input_word_valid,
    input  logic [WIDTH-1:0]              input_word_data,
    output logic                          output_word_ready,
    output logic                          output_load,
    output logic                          output_shift,
    output logic                          output_sdata,
    output logic                          output_bit_valid,
    output logic                          output_last,
    output logic                          output_busy,
    output logic [idx_width(WIDTH)-1:0]   output_bit_idx
);

    localparam int IDX_W = idx_width(WIDTH);
    localparam int NBITS = frame_bits(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBITS - 1);

    state_t                  state;
    logic [WIDTH-1:0]        shadow;
    logic [(1<<IDX_W)-1:0]   frame;
    logic [IDX_W-1:0]        next_idx;
    logic                    div_wrap_next;
    logic                    gap_wrap_next;
    logic                    gap_end;

    // Frame bits laid out in transmit order so bit_idx addresses them directly.
    always_comb begin
        frame = '0;
        for (int i = 0; i < WIDTH; i++) begin
            frame[i] = shadow[WIDTH-1-i];
        end
`ifdef SERIALIZE_SEQ_PARITY_EN
        frame[WIDTH] = ^shadow;
`endif
    end

    assign next_idx = output_bit_idx + IDX_W'(1);

    serialize_seq_period_cnt #(.MOD(DIV)) u_div_cnt (
        .clk       (input_clock_clk),
        .rst_n     (input_push_button_rst_n),
        .clear     (state == ST_LOAD),
        .en        (state == ST_SHIFT),
        .wrap_next (div_wrap_next)
    );

    serialize_seq_period_cnt #(.MOD((GAP > 0) ? GAP : 1)) u_gap_cnt (
        .clk       (input_clock_clk),
        .rst_n     (input_push_button_rst_n),
        .clear     (state != ST_GAP),
        .en        (1'b1),
        .wrap_next (gap_wrap_next)
    );

    // The registered shift strobe doubles as "this is the bit's last cycle".
    always_ff @(posedge input_clock_clk or negedge input_push_button_rst_n) begin
        if (!input_push_button_rst_n) begin
            state             <= ST_IDLE;
            shadow            <= '0;
            output_word_ready <= 1'b1;
            output_load       <= 1'b0;
            output_shift      <= 1'b0;
            output_sdata      <= 1'b0;
            output_bit_valid  <= 1'b0;
            output_last       <= 1'b0;
            output_busy       <= 1'b0;
            output_bit_idx    <= '0;
            gap_end           <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (input_word_valid && output_word_ready) begin
                        shadow            <= input_word_data;
                        state             <= ST_LOAD;
                        output_word_ready <= 1'b0;
                        output_load       <= 1'b1;
                        output_busy       <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state            <= ST_SHIFT;
                    output_load      <= 1'b0;
                    output_bit_valid <= 1'b1;
                    output_bit_idx   <= '0;
                    output_sdata     <= frame[0];
                    output_last      <= (LAST_IDX == '0);
                    output_shift     <= div_wrap_next;
                end
                ST_SHIFT: begin
                    if (output_shift && (output_bit_idx == LAST_IDX)) begin
                        output_bit_valid <= 1'b0;
                        output_shift     <= 1'b0;
                        output_last      <= 1'b0;
                        output_sdata     <= 1'b0;
                        if (GAP > 0) begin
                            state   <= ST_GAP;
                            gap_end <= gap_wrap_next;
                        end else begin
                            state             <= ST_IDLE;
                            output_busy       <= 1'b0;
                            output_word_ready <= 1'b1;
                            output_bit_idx    <= '0;
                        end
                    end else if (output_shift) begin
                        output_bit_idx <= next_idx;
                        output_sdata   <= frame[next_idx];
                        output_last    <= (next_idx == LAST_IDX);
                        output_shift   <= div_wrap_next;
                    end else begin
                        output_shift <= div_wrap_next;
                    end
                end
                ST_GAP: begin
                    if (gap_end) begin
                        state             <= ST_IDLE;
                        output_busy       <= 1'b0;
                        output_word_ready <= 1'b1;
                        output_bit_idx    <= '0;
                        gap_end           <= 1'b0;
                    end else begin
                        gap_end <= gap_wrap_next;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serialize_seq_ctrl.sv
// Bench for serialize_seq_ctrl: three DIV/GAP variants on shared stimulus,
// each checked against a per-frame expected timeline.
module tb_serialize_seq_ctrl;

    localparam int W = 4;
`ifdef SERIALIZE_SEQ_PARITY_EN
    localparam int FB = W + 1;
`else
    localparam int FB = W;
`endif
    localparam logic [9:0] IDLE_V = 10'b10_0000_0000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] data  = 4'd0;

    logic rdy [3];
    logic ld  [3];
    logic sh  [3];
    logic sd  [3];
    logic bv  [3];
    logic lst [3];
    logic bsy [3];
    logic [2:0] idx [3];

    // Expected output vectors {ready,load,shift,sdata,bit_valid,last,busy,idx}, one per cycle.
    logic [9:0] q [3][$];
    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    function automatic int div_of(input int k);
        return (k == 1) ? 3 : 1;
    endfunction

    function automatic int gap_of(input int k);
        return (k == 2) ? 0 : 1;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        serialize_seq_ctrl #(.WIDTH(W), .DIV(div_of(g)), .GAP(gap_of(g))) dut (
            .input_clock_clk         (clk),
            .input_push_button_rst_n (rst_n),
            .input_word_valid        (valid),
            .input_word_data         (data),
            .output_word_ready       (rdy[g]),
            .output_load             (ld[g]),
            .output_shift            (sh[g]),
            .output_sdata            (sd[g]),
            .output_bit_valid        (bv[g]),
            .output_last             (lst[g]),
            .output_busy             (bsy[g]),
            .output_bit_idx          (idx[g])
        );
    end

    function automatic logic [9:0] vec(input logic l, input logic s, input logic d,
                                       input logic v, input logic t, input logic [2:0] i);
        return {1'b0, l, s, d, v, t, 1'b1, i};
    endfunction

    task automatic push_frame(input logic [1:0] k, input logic [3:0] w);
        logic b;
        int   dv;
        dv = div_of(int'(k));
        q[k].push_back(vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        for (int i = 0; i < FB; i++) begin
            b = (i < W) ? w[2'(W-1-i)] : ^w;
            for (int c = 0; c < dv; c++) begin
                q[k].push_back(vec(1'b0, c == dv - 1, b, 1'b1, i == FB - 1, 3'(i)));
            end
        end
        for (int g = 0; g < gap_of(int'(k)); g++) begin
            q[k].push_back(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        end
    endtask

    function automatic logic [9:0] exp_of(input logic [1:0] k);
        return (q[k].size() != 0) ? q[k][0] : IDLE_V;
    endfunction

    // bit_idx is only meaningful while bit_valid is expected.
    function automatic logic [9:0] got_of(input logic [1:0] k, input logic [9:0] e);
        return {rdy[k], ld[k], sh[k], sd[k], bv[k], lst[k], bsy[k], e[5] ? idx[k] : 3'd0};
    endfunction

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            logic [1:0] kk;
            logic       hs;
            kk = 2'(k);
            if (!rst_n) begin
                q[kk].delete();
            end else begin
                hs = valid && (q[kk].size() == 0);
                if (q[kk].size() != 0) void'(q[kk].pop_front());
                if (hs) push_frame(kk, data);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (got_of(2'(k), IDLE_V) !== IDLE_V) begin
                fails++;
                $display("[TB] FAIL reset_held dut%0d got=%b exp=%b", k, got_of(2'(k), IDLE_V), IDLE_V);
            end
        end
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (got_of(2'(k), exp_of(2'(k))) !== exp_of(2'(k))) begin
                fails++;
                $display("[TB] FAIL reset_release dut%0d got=%b exp=%b", k, got_of(2'(k), exp_of(2'(k))), exp_of(2'(k)));
            end
        end
    endtask

    task automatic test_frame(input logic [3:0] w);
        int shifts [3] = '{0, 0, 0};
        for (int n = 0; n < 22; n++) begin
            for (int k = 0; k < 3; k++) begin
                logic [9:0] e;
                e = exp_of(2'(k));
                shifts[k] += int'(sh[k]);
                checks++;
                if (got_of(2'(k), e) !== e) begin
                    fails++;
                    $display("[TB] FAIL frame_%b dut%0d cyc%0d got=%b exp=%b", w, k, n, got_of(2'(k), e), e);
                end
            end
            valid = (n == 0);
            data  = (n == 0) ? w : 4'($urandom);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (shifts[k] != FB) begin
                fails++;
                $display("[TB] FAIL shift_count_%b dut%0d got=%0d exp=%0d", w, k, shifts[k], FB);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int shifts = 0;
        valid = 1'b1;
        data  = 4'b1011;
        tick();
        valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            q[k].delete();
            checks++;
            if (got_of(2'(k), IDLE_V) !== IDLE_V) begin
                fails++;
                $display("[TB] FAIL async_reset dut%0d got=%b exp=%b", k, got_of(2'(k), IDLE_V), IDLE_V);
            end
        end
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 22; n++) begin
            for (int k = 0; k < 3; k++) begin
                logic [9:0] e;
                e = exp_of(2'(k));
                checks++;
                if (got_of(2'(k), e) !== e) begin
                    fails++;
                    $display("[TB] FAIL after_reset dut%0d cyc%0d got=%b exp=%b", k, n, got_of(2'(k), e), e);
                end
            end
            shifts += int'(sh[0]);
            valid = (n == 0);
            data  = 4'b1000;
            tick();
        end
        checks++;
        if (shifts != FB) begin
            fails++;
            $display("[TB] FAIL after_reset_shifts got=%0d exp=%0d", shifts, FB);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 60; n++) begin
            for (int k = 0; k < 3; k++) begin
                logic [9:0] e;
                e = exp_of(2'(k));
                checks++;
                if (got_of(2'(k), e) !== e) begin
                    fails++;
                    $display("[TB] FAIL back_to_back dut%0d cyc%0d got=%b exp=%b", k, n, got_of(2'(k), e), e);
                end
            end
            if (n == FB + 3) begin
                checks++;
                if (rdy[0] !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL b2b_ready_gap1 got=%b exp=1", rdy[0]);
                end
            end
            if (n == FB + 4) begin
                checks++;
                if (ld[0] !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL b2b_second_load got=%b exp=1", ld[0]);
                end
            end
            if (n == FB + 2) begin
                checks++;
                if (rdy[2] !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL b2b_ready_gap0 got=%b exp=1", rdy[2]);
                end
            end
            valid = (n < 40);
            if (n == 0)           data = 4'b1111;
            else if (n == FB + 3) data = 4'b0001;
            else                  data = 4'($urandom);
            tick();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 3; k++) begin
                logic [9:0] e;
                e = exp_of(2'(k));
                checks++;
                if (got_of(2'(k), e) !== e) begin
                    fails++;
                    $display("[TB] FAIL random dut%0d cyc%0d got=%b exp=%b", k, n, got_of(2'(k), e), e);
                end
                checks++;
                if ((ld[k] && sh[k]) !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL load_shift_overlap dut%0d cyc%0d got=1 exp=0", k, n);
                end
            end
            valid = (n < 370) && ($urandom_range(0, 9) < 7);
            data  = 4'($urandom);
            tick();
        end
    endtask

    initial begin
        $display("[TB] start, frame bits %0d", FB);
        test_reset();
        test_frame(4'b1011);
        test_frame(4'b0110);
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/serialize_seq_ctrl.md
Name: serialize_seq_ctrl

Overview:
Load/shift sequencer for the parallel-in serial-out serialize/register datapath.
- Accepts a parallel word over a valid/ready handshake.
- Issues a one-cycle load strobe to the register, then paces WIDTH shift strobes with a programmable bit period.
- Drives the serial bit and framing flags (bit valid, last, busy) to the downstream consumer and the LED indicators.
- Replaces the free-running slow-clock load/shift toggle with a deterministic, handshaked sequence.

Parameters:
WIDTH, 4, data word width in bits (>=2)
DIV, 1, clock cycles per serial bit (>=1)
GAP, 1, idle cycles inserted after each word before ready reasserts (>=0)

Ports:
input_clock_clk  input  1  single system clock, all state changes on rising edge
input_push_button_rst_n  input  1  asynchronous active-low reset
input_word_valid  input  1  upstream word valid
input_word_data  input  WIDTH  upstream parallel word
output_word_ready  output  1  controller can accept a word
output_load  output  1  one-cycle parallel-load strobe to register
output_shift  output  1  one-cycle shift strobe, last cycle of each bit period
output_sdata  output  1  current serial bit, MSB first
output_bit_valid  output  1  output_sdata is meaningful
output_last  output  1  current bit is the final bit of the frame
output_busy  output  1  frame in progress (any state but IDLE)
output_bit_idx  output  $clog2(WIDTH+1)  index of current bit, 0 = first

Behaviour:
- Clocking and reset: one clock, input_clock_clk. Reset is input_push_button_rst_n, asynchronous, active-low.
- While reset is low: state=IDLE, shadow=0, counters=0, ready=1, all other outputs 0.
- States (2-bit) and transitions:
  - IDLE: ready=1. Handshake = valid&&ready captures data into shadow, then go to LOAD.
  - LOAD: exactly 1 cycle, load=1, ready=0, then go to SHIFT with bit_idx=0 and period counter=0.
  - SHIFT: bit_valid=1, sdata=shadow[WIDTH-1-bit_idx].
    - Period counter counts 0..DIV-1. shift=1 when counter==DIV-1; bit_idx increments on that cycle.
    - last=1 for all cycles of the final bit.
    - After the final bit's shift cycle: go to GAP if GAP>0, else IDLE.
  - GAP: counts GAP cycles, all strobes 0, busy=1, then go to IDLE.
- Latency: handshake in cycle 0, load in cycle 1, first bit cycles 2..DIV+1. Frame length is 1+WIDTH*DIV+GAP cycles after the handshake.
- Data capture:
  - input_word_data is sampled only at the handshake. Later changes never affect the frame.
  - valid asserted while not IDLE is ignored, with no queueing.
  - Back-to-back: valid held high gives the next handshake on the first IDLE cycle.
- Simultaneous events: reset dominates everything. Reset mid-frame aborts the frame immediately; sdata, load, shift and flags drop asynchronously. No partial strobes after release.
- Strobe rules: load and shift are never high in the same cycle. Exactly WIDTH shift pulses are issued per frame.
- Width rules: bit_idx saturates at its final value; it never wraps within a frame. DIV=1 gives shift=1 on every SHIFT cycle.

Optional Feature:
Macro SERIALIZE_SEQ_PARITY_EN.
- Defined: one even-parity bit (XOR of shadow) is appended after the data bits.
  - It is output with bit_idx=WIDTH and takes DIV cycles plus one extra shift pulse.
  - last moves to the parity bit.
  - Frame length is 1+(WIDTH+1)*DIV+GAP.
- Undefined: no parity bit; bit_idx never reaches WIDTH.

Decomposition:
- Package serialize_seq_pkg:
  - state typedef with encodings IDLE=0, LOAD=1, SHIFT=2, GAP=3
  - function computing bit_idx width from WIDTH
  - localparam for the parity-extended frame bit count
- Sub-module serialize_seq_period_cnt: DIV-cycle bit-period counter with clear and terminal-count output, reused for the GAP count.

Test Plan:
1. WIDTH=4, DIV=1, GAP=1; data=4'b1011 with handshake at cycle 0:
   - load at cycle 1
   - sdata 1,0,1,1 in cycles 2-5, shift high in cycles 2-5, last at cycle 5
   - busy cycles 1-6, ready=1 again at cycle 7
2. DIV=3, data=4'b0110:
   - each bit held 3 cycles
   - shift pulses at cycles 4,7,10,13, bit_idx 0..3
   - ready returns at cycle 15
3. Reset low at cycle 3 of a DIV=1 frame:
   - outputs 0 and ready=1 immediately
   - after release, a new word 4'b1000 serializes 1,0,0,0 with no residual strobes
4. valid held high with data 4'b1111 then 4'b0001:
   - second handshake at cycle 7
   - data toggled during SHIFT does not alter sdata
5. SERIALIZE_SEQ_PARITY_EN, data=4'b1011:
   - bits 1,0,1,1,1
   - last only on the 5th bit (bit_idx=4), 5 shift pulses
6. GAP=0, DIV=1, valid always high:
   - ready on cycle 6, frames every 6 cycles
   - load never coincides with shift
